// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and a one-entry skid buffer.
// The skid buffer catches the single in-flight memory response when decode stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 jump,
    input  logic [31:0]          next,
    output logic [31:0]          imem_addr,
    output logic                 imem_req,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic                 id_valid,
    output logic [CNT_WIDTH-1:0] redirect_count,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_STREAM = 2'd1,
        ST_HELD   = 2'd2
    } fetch_state_e;

    logic [31:0]          pc_q, pc_d;
    logic                 f_valid_q, f_valid_d;
    logic [31:0]          f_pc_q, f_pc_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [31:0]          skid_instr_q, skid_instr_d;
    logic [31:0]          skid_pc_q, skid_pc_d;
    logic [31:0]          id_instr_q, id_instr_d;
    logic [31:0]          id_pc_q, id_pc_d;
    logic                 id_valid_q, id_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    fetch_state_e         state;

    // Handshake: a request issued in cycle t returns on imem_rdata in t+1 with no
    // back-pressure; decode back-pressures us with stall, so the one response
    // already in flight when stall rises is parked in the skid buffer.
    assign imem_req       = !reset && !stall && !jump;
    assign imem_addr      = pc_q;
    assign id_instr       = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_valid       = id_valid_q;
    assign redirect_count = cnt_q;

    always_comb begin
        state = ST_EMPTY;
        if (skid_valid_q)   state = ST_HELD;
        else if (f_valid_q) state = ST_STREAM;
    end
    assign dbg_state = state;

    always_comb begin
        pc_d         = pc_q;
        f_valid_d    = f_valid_q;
        f_pc_d       = f_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        cnt_d        = cnt_q;

        if (jump) begin
            pc_d         = next;
            f_valid_d    = 1'b0;
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (stall) begin
            f_valid_d = 1'b0;
            if (f_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = f_pc_q;
            end
        end else begin
            pc_d      = pc_q + 32'd1;
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            if (skid_valid_q) begin
                id_instr_d   = skid_instr_q;
                id_pc_d      = skid_pc_q;
                id_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                id_instr_d = imem_rdata;
                id_pc_d    = f_pc_q;
                id_valid_d = f_valid_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            f_valid_q    <= 1'b0;
            f_pc_q       <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            id_instr_q   <= 32'h0;
            id_pc_q      <= 32'h0;
            id_valid_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: default instance, a 4-bit counter instance and a wrap-around
// RESET_PC instance share stimulus; each has its own model memory mem[a] = 0x1000 + a.
module tb_fetch_stage;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] nxt = 32'h0;

    logic [31:0] addr_m, rdata_m = '0, instr_m, pc_m;
    logic        req_m, valid_m;
    logic [15:0] cnt_m;
    logic [1:0]  st_m;

    logic [31:0] addr_c, rdata_c = '0, instr_c, pc_c;
    logic        req_c, valid_c;
    logic [3:0]  cnt_c;
    logic [1:0]  st_c;

    logic [31:0] addr_w, rdata_w = '0, instr_w, pc_w;
    logic        req_w, valid_w;
    logic [15:0] cnt_w;
    logic [1:0]  st_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic        upd_pending = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .next(nxt),
        .imem_addr(addr_m), .imem_req(req_m), .imem_rdata(rdata_m),
        .id_instr(instr_m), .id_pc(pc_m), .id_valid(valid_m),
        .redirect_count(cnt_m), .dbg_state(st_m)
    );

    fetch_stage #(.CNT_WIDTH(4)) dut_cnt4 (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .next(nxt),
        .imem_addr(addr_c), .imem_req(req_c), .imem_rdata(rdata_c),
        .id_instr(instr_c), .id_pc(pc_c), .id_valid(valid_c),
        .redirect_count(cnt_c), .dbg_state(st_c)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .next(nxt),
        .imem_addr(addr_w), .imem_req(req_w), .imem_rdata(rdata_w),
        .id_instr(instr_w), .id_pc(pc_w), .id_valid(valid_w),
        .redirect_count(cnt_w), .dbg_state(st_w)
    );

    always @(posedge clk) begin
        if (req_m) rdata_m <= 32'h1000 + addr_m;
        if (req_c) rdata_c <= 32'h1000 + addr_c;
        if (req_w) rdata_w <= 32'h1000 + addr_w;
    end

    // Scoreboard: every issued request pushes its expected IF/ID contents; every
    // IF/ID update carrying a valid instruction pops and compares.
    always @(negedge clk) begin
        logic [63:0] e;
        if (upd_pending && valid_m) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected got pc=%h instr=%h, required no output", pc_m, instr_m);
            end else begin
                e = exp_q.pop_front();
                if ({instr_m, pc_m} !== e) begin
                    n_fail++;
                    $display("FAIL sb_ifid got instr=%h pc=%h, required instr=%h pc=%h",
                             instr_m, pc_m, e[63:32], e[31:0]);
                end
            end
        end
        if (reset) begin
            exp_q.delete();
            upd_pending = 1'b0;
        end else begin
            if (jump) exp_q.delete();
            upd_pending = !stall && !jump;
            if (req_m) exp_q.push_back({32'h1000 + addr_m, addr_m});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout, required finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; jump = 1'b0; nxt = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; jump = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (addr_m !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h required 0", addr_m); end
        n_tests++; if (req_m !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b required 0", req_m); end
        n_tests++; if ({instr_m, pc_m} !== 64'h0) begin n_fail++; $display("FAIL rst_ifid got %h/%h required 0", instr_m, pc_m); end
        n_tests++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b required 0", valid_m); end
        n_tests++; if (cnt_m !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got %h required 0", cnt_m); end
        n_tests++; if (st_m !== ST_EMPTY) begin n_fail++; $display("FAIL rst_state got %0d required %0d", st_m, ST_EMPTY); end
        n_tests++; if (addr_w !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_wrap_addr got %h required ffffffff", addr_w); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++; if (addr_m !== 32'(c)) begin n_fail++; $display("FAIL stream_addr c=%0d got %h required %h", c, addr_m, 32'(c)); end
            n_tests++; if (req_m !== 1'b1) begin n_fail++; $display("FAIL stream_req c=%0d got %b required 1", c, req_m); end
            n_tests++; if (valid_m !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b required %b", c, valid_m, c >= 2); end
            if (c >= 2) begin
                e = 32'(c - 2);
                n_tests++; if (pc_m !== e || instr_m !== 32'h1000 + e) begin
                    n_fail++; $display("FAIL stream_ifid c=%0d got %h/%h required %h/%h", c, pc_m, instr_m, e, 32'h1000 + e);
                end
            end
            e = 32'hFFFF_FFFF + 32'(c);
            n_tests++; if (addr_w !== e) begin n_fail++; $display("FAIL wrap_addr c=%0d got %h required %h", c, addr_w, e); end
            if (c >= 2) begin
                e = 32'hFFFF_FFFF + 32'(c - 2);
                n_tests++; if (pc_w !== e || !valid_w) begin n_fail++; $display("FAIL wrap_idpc c=%0d got %h required %h", c, pc_w, e); end
            end
            tick();
        end
    endtask

    task automatic test_stall(input int s, input int n);
        logic [31:0] ea, ep;
        do_reset();
        for (int c = 0; c < s + n + 5; c++) begin
            stall = (c >= s && c < s + n);
            @(negedge clk);
            ea = (c < s) ? 32'(c) : (c < s + n) ? 32'(s) : 32'(c - n);
            ep = (c <= s) ? 32'(c - 2) : (c <= s + n) ? 32'(s - 2) : 32'(c - 2 - n);
            n_tests++; if (req_m !== !stall) begin n_fail++; $display("FAIL stall_req s=%0d n=%0d c=%0d got %b required %b", s, n, c, req_m, !stall); end
            n_tests++; if (addr_m !== ea) begin n_fail++; $display("FAIL stall_addr s=%0d n=%0d c=%0d got %h required %h", s, n, c, addr_m, ea); end
            if (c >= 2) begin
                n_tests++; if (!valid_m || pc_m !== ep || instr_m !== 32'h1000 + ep) begin
                    n_fail++; $display("FAIL stall_ifid s=%0d n=%0d c=%0d got v=%b %h/%h required %h", s, n, c, valid_m, pc_m, instr_m, ep);
                end
            end
            if (c > s && c <= s + n) begin
                n_tests++; if (st_m !== ST_HELD) begin n_fail++; $display("FAIL stall_state c=%0d got %0d required %0d", c, st_m, ST_HELD); end
            end
            if (c == s + n + 2) begin
                n_tests++; if (st_m !== ST_STREAM) begin n_fail++; $display("FAIL stall_resume_state c=%0d got %0d required %0d", c, st_m, ST_STREAM); end
            end
            tick();
        end
        stall = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] ep;
        do_reset();
        nxt = 32'h40;
        for (int c = 0; c < 13; c++) begin
            jump = (c == 7);
            @(negedge clk);
            if (c == 7) begin
                n_tests++; if (req_m !== 1'b0 || pc_m !== 32'h5) begin n_fail++; $display("FAIL jump_cycle got req=%b pc=%h required 0/5", req_m, pc_m); end
            end
            if (c >= 8) begin
                n_tests++; if (addr_m !== 32'h40 + 32'(c - 8)) begin n_fail++; $display("FAIL jump_addr c=%0d got %h required %h", c, addr_m, 32'h40 + 32'(c - 8)); end
                n_tests++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL jump_cnt c=%0d got %0d required 1", c, cnt_m); end
                n_tests++; if (valid_m !== (c >= 10)) begin n_fail++; $display("FAIL jump_valid c=%0d got %b required %b", c, valid_m, c >= 10); end
            end
            if (c >= 10) begin
                ep = 32'h40 + 32'(c - 10);
                n_tests++; if (pc_m !== ep || instr_m !== 32'h1000 + ep) begin n_fail++; $display("FAIL jump_ifid c=%0d got %h/%h required %h", c, pc_m, instr_m, ep); end
            end
            tick();
        end
        jump = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ep;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            stall = (c == 5 || c == 6);
            jump  = (c == 6 || c == 7);
            nxt   = (c == 6) ? 32'h10 : 32'h20;
            @(negedge clk);
            if (c == 6) begin
                n_tests++; if (st_m !== ST_HELD) begin n_fail++; $display("FAIL b2b_held got %0d required %0d", st_m, ST_HELD); end
            end
            if (c == 7) begin
                n_tests++; if (st_m !== ST_EMPTY || cnt_m !== 16'd1) begin n_fail++; $display("FAIL b2b_first got st=%0d cnt=%0d required 0/1", st_m, cnt_m); end
            end
            if (c >= 7) begin
                n_tests++; if (valid_m !== (c >= 10)) begin n_fail++; $display("FAIL b2b_valid c=%0d got %b required %b", c, valid_m, c >= 10); end
            end
            if (c >= 8) begin
                n_tests++; if (cnt_m !== 16'd2 || addr_m !== 32'h20 + 32'(c - 8)) begin
                    n_fail++; $display("FAIL b2b_cnt_addr c=%0d got %0d/%h required 2/%h", c, cnt_m, addr_m, 32'h20 + 32'(c - 8));
                end
            end
            if (c >= 10) begin
                ep = 32'h20 + 32'(c - 10);
                n_tests++; if (pc_m !== ep || instr_m !== 32'h1000 + ep) begin n_fail++; $display("FAIL b2b_ifid c=%0d got %h/%h required %h", c, pc_m, instr_m, ep); end
            end
            tick();
        end
        stall = 1'b0; jump = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        nxt = 32'h100;
        for (int k = 0; k < 22; k++) begin
            jump = (k < 20);
            @(negedge clk);
            n_tests++; if (cnt_c !== 4'((k > 15) ? 15 : k)) begin n_fail++; $display("FAIL sat_cnt4 k=%0d got %0d required %0d", k, cnt_c, (k > 15) ? 15 : k); end
            n_tests++; if (cnt_m !== 16'((k > 20) ? 20 : k)) begin n_fail++; $display("FAIL sat_cnt16 k=%0d got %0d required %0d", k, cnt_m, (k > 20) ? 20 : k); end
            tick();
        end
        jump = 1'b0;
    endtask

    task automatic test_midreset();
        do_reset();
        nxt = 32'h80;
        for (int c = 0; c < 6; c++) begin
            jump = (c == 2);
            tick();
        end
        jump = 1'b0;
        #2;
        n_tests++; if (valid_m !== 1'b1 || cnt_m !== 16'd1) begin n_fail++; $display("FAIL mid_pre got v=%b cnt=%0d required 1/1", valid_m, cnt_m); end
        reset = 1'b1;
        #1;
        n_tests++; if (valid_m !== 1'b0 || pc_m !== 32'h0 || instr_m !== 32'h0) begin n_fail++; $display("FAIL mid_ifid got v=%b %h/%h required 0", valid_m, pc_m, instr_m); end
        n_tests++; if (addr_m !== 32'h0 || req_m !== 1'b0 || cnt_m !== 16'h0) begin n_fail++; $display("FAIL mid_ctl got %h/%b/%0d required 0/0/0", addr_m, req_m, cnt_m); end
        n_tests++; if (addr_w !== 32'hFFFF_FFFF || st_m !== ST_EMPTY) begin n_fail++; $display("FAIL mid_wrap got %h st=%0d required ffffffff/0", addr_w, st_m); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (addr_m !== 32'(c)) begin n_fail++; $display("FAIL mid_restart_addr c=%0d got %h required %h", c, addr_m, 32'(c)); end
            n_tests++; if (valid_m !== (c >= 2) || (c >= 2 && pc_m !== 32'(c - 2))) begin
                n_fail++; $display("FAIL mid_restart_ifid c=%0d got v=%b pc=%h", c, valid_m, pc_m);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall(6, 1);
        test_stall(5, 5);
        test_jump();
        test_back_to_back();
        test_saturate();
        test_midreset();
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
